// File: rtl/fifo_buffer.sv
// rtl/fifo_buffer.sv - fixed-latency coefficient delay line; optional occupancy port via FIFO_BUFFER_OCCUPANCY_EN
module fifo_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           coeff_tl,
    input  logic [WIDTH-1:0]           coeff_tr,
    input  logic [WIDTH-1:0]           coeff_bl,
    input  logic [WIDTH-1:0]           coeff_br,
    output logic [WIDTH-1:0]           coeff_tl_out,
    output logic [WIDTH-1:0]           coeff_tr_out,
    output logic [WIDTH-1:0]           coeff_bl_out,
    output logic [WIDTH-1:0]           coeff_br_out,
    output logic                       out_valid
`ifdef FIFO_BUFFER_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int EW = 4 * WIDTH;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [FW-1:0] FULL     = FW'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [FW-1:0] fill;
    logic [EW-1:0] rd_entry;
    logic          primed;
    logic          advance;

    // The slot about to be overwritten holds the entry written DEPTH advances ago.
    assign rd_entry = mem[wr_ptr];
    assign primed   = (fill == FULL);
    assign advance  = start && !rst;

    // Storage has no reset; stale contents are masked until fill saturates.
    always_ff @(posedge clk) begin
        if (advance) begin
            mem[wr_ptr] <= {coeff_tl, coeff_tr, coeff_bl, coeff_br};
        end
    end

    // Pointer, fill level and registered outputs; everything holds while start is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            fill         <= '0;
            coeff_tl_out <= '0;
            coeff_tr_out <= '0;
            coeff_bl_out <= '0;
            coeff_br_out <= '0;
            out_valid    <= 1'b0;
        end else if (start) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            if (primed) begin
                {coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out} <= rd_entry;
                out_valid <= 1'b1;
            end else begin
                coeff_tl_out <= '0;
                coeff_tr_out <= '0;
                coeff_bl_out <= '0;
                coeff_br_out <= '0;
                out_valid    <= 1'b0;
                fill         <= fill + FW'(1);
            end
        end
    end

`ifdef FIFO_BUFFER_OCCUPANCY_EN
    assign occupancy = fill;
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// tb/tb_fifo_buffer.sv - directed self-checking bench for fifo_buffer at DEPTH=20
module tb_fifo_buffer;

    localparam int DEPTH = 20;
    localparam int WIDTH = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] coeff_tl, coeff_tr, coeff_bl, coeff_br;
    logic [WIDTH-1:0] coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out;
    logic             out_valid;
`ifdef FIFO_BUFFER_OCCUPANCY_EN
    logic [4:0]       occupancy;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    fifo_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .coeff_tl     (coeff_tl),
        .coeff_tr     (coeff_tr),
        .coeff_bl     (coeff_bl),
        .coeff_br     (coeff_br),
        .coeff_tl_out (coeff_tl_out),
        .coeff_tr_out (coeff_tr_out),
        .coeff_bl_out (coeff_bl_out),
        .coeff_br_out (coeff_br_out),
        .out_valid    (out_valid)
`ifdef FIFO_BUFFER_OCCUPANCY_EN
        ,
        .occupancy    (occupancy)
`endif
    );

    always #5 clk = ~clk;

    // Coefficient pattern for index v: tl=v, tr=v+100, bl=v+200, br=v+300.
    function automatic logic [4*WIDTH-1:0] pack(input int v);
        return {10'(v), 10'(v + 100), 10'(v + 200), 10'(v + 300)};
    endfunction

    // Drive one cycle, then sample 1 time unit after the rising edge.
    task automatic drive(input logic r, input logic st, input int v);
        rst      = r;
        start    = st;
        coeff_tl = 10'(v);
        coeff_tr = 10'(v + 100);
        coeff_bl = 10'(v + 200);
        coeff_br = 10'(v + 300);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            rst = 1'b1; start = 1'b1;
            coeff_tl = 10'h3FF; coeff_tr = 10'h3FF; coeff_bl = 10'h3FF; coeff_br = 10'h3FF;
            @(posedge clk);
            #1;
            n_cmp++;
            if ({coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out, out_valid} !== 41'd0) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %h/%b want 0/0", c,
                         {coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out}, out_valid);
            end
`ifdef FIFO_BUFFER_OCCUPANCY_EN
            n_cmp++;
            if (occupancy !== 5'd0) begin
                n_fail++;
                $display("FAIL reset_occupancy cycle %0d: got %0d want 0", c, occupancy);
            end
`endif
        end
    endtask

    task automatic test_latency();
        for (int i = 1; i <= 40; i++) begin
            logic [4*WIDTH-1:0] exp_d;
            logic               exp_v;
            drive(1'b0, 1'b1, i);
            exp_v = (i > DEPTH);
            exp_d = exp_v ? pack(i - DEPTH) : '0;
            n_cmp++;
            if ({coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out, out_valid} !== {exp_d, exp_v}) begin
                n_fail++;
                $display("FAIL latency edge %0d: got %h/%b want %h/%b", i,
                         {coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out}, out_valid, exp_d, exp_v);
            end
`ifdef FIFO_BUFFER_OCCUPANCY_EN
            n_cmp++;
            if (occupancy !== 5'((i < DEPTH) ? i : DEPTH)) begin
                n_fail++;
                $display("FAIL occupancy edge %0d: got %0d want %0d", i, occupancy, (i < DEPTH) ? i : DEPTH);
            end
`endif
        end
    endtask

    // Continues from test_latency: last input 40, current output 20.
    task automatic test_stall();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, 700 + c * 37);
            n_cmp++;
            if ({coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out, out_valid} !== {pack(20), 1'b1}) begin
                n_fail++;
                $display("FAIL stall cycle %0d: got %h/%b want %h/1", c,
                         {coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out}, out_valid, pack(20));
            end
`ifdef FIFO_BUFFER_OCCUPANCY_EN
            n_cmp++;
            if (occupancy !== 5'd20) begin
                n_fail++;
                $display("FAIL stall_occupancy cycle %0d: got %0d want 20", c, occupancy);
            end
`endif
        end
        for (int i = 41; i <= 45; i++) begin
            drive(1'b0, 1'b1, i);
            n_cmp++;
            if ({coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out, out_valid} !== {pack(i - DEPTH), 1'b1}) begin
                n_fail++;
                $display("FAIL resume input %0d: got %h/%b want %h/1", i,
                         {coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out}, out_valid, pack(i - DEPTH));
            end
        end
    endtask

    // Three full pointer revolutions of continuous advance.
    task automatic test_wrap();
        for (int i = 46; i < 46 + 3 * DEPTH; i++) begin
            drive(1'b0, 1'b1, i);
            n_cmp++;
            if ({coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out, out_valid} !== {pack(i - DEPTH), 1'b1}) begin
                n_fail++;
                $display("FAIL wrap input %0d: got %h/%b want %h/1", i,
                         {coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out}, out_valid, pack(i - DEPTH));
            end
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b0, 0);
        for (int j = 1; j <= 30; j++) begin
            drive(1'b0, 1'b1, 500 + j);
        end
        n_cmp++;
        if ({coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out, out_valid} !== {pack(510), 1'b1}) begin
            n_fail++;
            $display("FAIL pre_reset: got %h/%b want %h/1",
                     {coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out}, out_valid, pack(510));
        end
        drive(1'b1, 1'b1, 999);
        n_cmp++;
        if ({coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out, out_valid} !== 41'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h/%b want 0/0",
                     {coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out}, out_valid);
        end
`ifdef FIFO_BUFFER_OCCUPANCY_EN
        n_cmp++;
        if (occupancy !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_reset_occupancy: got %0d want 0", occupancy);
        end
`endif
        for (int j = 1; j <= 25; j++) begin
            logic [4*WIDTH-1:0] exp_d;
            logic               exp_v;
            drive(1'b0, 1'b1, 600 + j);
            exp_v = (j > DEPTH);
            exp_d = exp_v ? pack(600 + j - DEPTH) : '0;
            n_cmp++;
            if ({coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out, out_valid} !== {exp_d, exp_v}) begin
                n_fail++;
                $display("FAIL reprime edge %0d: got %h/%b want %h/%b", j,
                         {coeff_tl_out, coeff_tr_out, coeff_bl_out, coeff_br_out}, out_valid, exp_d, exp_v);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        coeff_tl = '0; coeff_tr = '0; coeff_bl = '0; coeff_br = '0;
        test_reset();
        test_latency();
        test_stall();
        test_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_buffer.md
Name: fifo_buffer

Overview:
- Fixed-latency delay line for the four bilinear-interpolation coefficients (top-left, top-right, bottom-left, bottom-right) in the undistort pipeline.
- Re-aligns the coefficients with pixel data that arrives DEPTH cycles later.
- Circular buffer of DEPTH entries; advances only while `start` is high.
- Outputs read zero until the buffer has been primed with DEPTH entries.

Parameters:
- DEPTH, 16: number of entries, equal to the delay in advancing cycles. Legal range is 2 or more; need not be a power of two.
- WIDTH, 10: bit width of each coefficient.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  advance enable; high means write one entry and read one entry this cycle.
- coeff_tl  in  WIDTH  top-left coefficient in.
- coeff_tr  in  WIDTH  top-right coefficient in.
- coeff_bl  in  WIDTH  bottom-left coefficient in.
- coeff_br  in  WIDTH  bottom-right coefficient in.
- coeff_tl_out  out  WIDTH  delayed top-left coefficient.
- coeff_tr_out  out  WIDTH  delayed top-right coefficient.
- coeff_bl_out  out  WIDTH  delayed bottom-left coefficient.
- coeff_br_out  out  WIDTH  delayed bottom-right coefficient.
- out_valid  out  1  high when the outputs hold a real delayed entry.

Behaviour:
- One clock, `clk`; `rst` is synchronous and active-high.
- State:
  - Storage: mem[0..DEPTH-1] of 4×WIDTH bits.
  - wr_ptr: 0..DEPTH-1.
  - fill: 0..DEPTH, saturating.
  - Four output registers and out_valid.
- Reset (rst=1 at an edge):
  - wr_ptr=0, fill=0, all four outputs=0, out_valid=0.
  - Memory contents are don't-care, because fill gating masks them.
  - rst has priority over start.
- Advance (start=1, rst=0), all in the same edge:
  - Read mem[wr_ptr] (old value, read-before-write).
  - Write {tl,tr,bl,br} inputs into mem[wr_ptr].
  - wr_ptr wraps: DEPTH-1 goes to 0.
  - If fill==DEPTH: outputs take the old value and out_valid goes to 1.
  - Otherwise: outputs go to 0, out_valid goes to 0, and fill increments.
- Latency:
  - An input sampled at the k-th advancing edge appears on the outputs after the (k+DEPTH)-th advancing edge.
  - With start held high this is exactly DEPTH clock cycles.
- Stall (start=0, rst=0):
  - Pointers, fill, memory, outputs and out_valid all hold.
  - Inputs are ignored.
  - After resuming, the sequence continues with no loss or duplication.
- Priming:
  - The first DEPTH advancing edges after reset output zeros with out_valid=0.
  - The (DEPTH+1)-th advancing edge outputs the first stored entry.
- Wrap-around: seamless; there is no full or empty error. In steady state every advance both evicts and inserts one entry.
- Reset mid-operation: all stored data is discarded and priming restarts.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: FIFO_BUFFER_OCCUPANCY_EN.
- Defined: adds output port `occupancy`, width $clog2(DEPTH+1), equal to the fill register.
  - 0 after reset.
  - Increments per advance until it saturates at DEPTH.
  - Holds during stall.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 and inputs 10'h3FF → all outputs 0 and out_valid=0 on both cycles.
- Latency, DEPTH=20:
  - Stimulus: release reset, hold start=1, feed tl=i, tr=i+100, bl=i+200, br=i+300 for i=1..40.
  - Outputs are 0 for the first 20 edges.
  - After edge 21, outputs read 1/101/201/301 with out_valid=1.
  - Thereafter outputs increment by 1 per cycle.
- Stall: after priming, drop start for 5 cycles while changing inputs → outputs and out_valid frozen. On resume, the next output is the entry that was due, with no skipped values.
- Wrap: run 3×DEPTH continuous advances with an incrementing pattern → output equals input delayed exactly DEPTH cycles across every pointer wrap.
- Reset mid-stream: assert rst for 1 cycle after 30 advances → outputs return to 0 and out_valid=0, and 20 further advances are needed before new data appears.
- With FIFO_BUFFER_OCCUPANCY_EN:
  - occupancy steps 0→20 over the first 20 advances, then stays at 20.
  - occupancy holds during stall.
  - occupancy clears to 0 on rst.
